mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single byte-wide memory/IO port, shared between the instruction-fetch line filler and the load/store buffer. Grants one requester at a time with two-way round-robin and serialises each transfer into per-byte address/data beats. Also handles the memory's one-cycle read latency, UART back-pressure on IO stores, rdy_in pauses and branch-flush aborts. Sits between IFetch/LSB and the top-level mem_* pins.

---
 rtl/mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the byte-wide memory/IO port between the
// instruction-fetch line filler and the load/store buffer. Two-way
// round-robin grant, per-byte beat sequencing, one-cycle read latency,
// UART back-pressure on IO stores, rdy_in pauses and flush aborts.
module mem_port_arbiter #(
   parameter int LINE_BYTES = 64
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    flush,
   input  logic                    io_buffer_full,
   input  logic [7:0]              mem_din,
   output logic [7:0]              mem_dout,
   output logic [31:0]             mem_a,
   output logic                    mem_wr,
   input  logic                    if_todo,
   input  logic [31:0]             if_addr,
   output logic [8*LINE_BYTES-1:0] if_res,
   output logic                    if_done,
   input  logic                    ls_todo,
   input  logic [31:0]             ls_addr,
   input  logic [2:0]              ls_len,
   input  logic                    ls_store,
   input  logic [31:0]             ls_wdata,
   output logic [31:0]             ls_rdata,
   output logic                    ls_done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;

   localparam int CW = 8;                    // beat counters, holds up to 64
   localparam int IW = $clog2(LINE_BYTES);   // byte index within the line
   localparam int RW = 8 * LINE_BYTES;       // line buffer width
   localparam int BW = IW + 3;               // bit offset within the line

   logic [1:0]    state, state_next;
   logic          last_ls, last_ls_next;     // last grant went to the LSB
   logic          owner_ls, owner_ls_next;   // current transfer belongs to the LSB
   logic [31:0]   base, base_next;
   logic [CW-1:0] len, len_next;
   logic [31:0]   wdata, wdata_next;
   logic [CW-1:0] beat_idx, beat_idx_next;   // index of the beat on mem_a now
   logic          beat_valid, beat_valid_next;
   logic [CW-1:0] cap_idx, cap_idx_next;     // index whose data is on mem_din now
   logic          cap_valid, cap_valid_next;
   logic [RW-1:0] rbuf, rbuf_next;

   logic [31:0]   mem_a_reg, mem_a_next;
   logic [7:0]    mem_dout_reg, mem_dout_next;
   logic          mem_wr_reg, mem_wr_next;
   logic [RW-1:0] if_res_reg, if_res_next;
   logic          if_done_reg, if_done_next;
   logic [31:0]   ls_rdata_reg, ls_rdata_next;
   logic          ls_done_reg, ls_done_next;

   logic          if_elig, ls_elig, grant_if, grant_ls;
   logic [CW-1:0] last_idx, step_idx, rewind_idx;
   logic [31:0]   step_addr, rewind_addr;
   logic [BW-1:0] cap_bit;
   logic [4:0]    wr_bit;
   logic [RW-1:0] rbuf_cap;
   logic [31:0]   ls_word;

   // Eligibility and round-robin choice; a requester is deaf in its done cycle
   always_comb begin
      if_elig  = if_todo && !if_done_reg;
      ls_elig  = ls_todo && !ls_done_reg &&
                 !(ls_store && (ls_addr[17:16] == 2'b11) && io_buffer_full);
      grant_if = if_elig && (!ls_elig || last_ls);
      grant_ls = ls_elig && !grant_if;
   end

   // Beat index arithmetic, byte capture merge and load-word assembly
   always_comb begin
      last_idx    = len - CW'(1);
      step_idx    = beat_idx + CW'(1);
      rewind_idx  = cap_valid ? cap_idx : beat_idx;
      step_addr   = base + {{(32-CW){1'b0}}, step_idx};
      rewind_addr = base + {{(32-CW){1'b0}}, rewind_idx};
      cap_bit     = {cap_idx[IW-1:0], 3'b000};
      wr_bit      = {step_idx[1:0], 3'b000};
      rbuf_cap    = rbuf;
      rbuf_cap[cap_bit +: 8] = mem_din;
      case (len[2:0])
         3'd1:    ls_word = {24'h0, rbuf_cap[7:0]};
         3'd2:    ls_word = {16'h0, rbuf_cap[15:0]};
         default: ls_word = rbuf_cap[31:0];
      endcase
   end

   // Next-state logic for the sequencer and all registered outputs
   always_comb begin
      state_next      = state;
      last_ls_next    = last_ls;
      owner_ls_next   = owner_ls;
      base_next       = base;
      len_next        = len;
      wdata_next      = wdata;
      beat_idx_next   = beat_idx;
      beat_valid_next = beat_valid;
      cap_idx_next    = cap_idx;
      cap_valid_next  = cap_valid;
      rbuf_next       = rbuf;
      mem_a_next      = mem_a_reg;
      mem_dout_next   = mem_dout_reg;
      mem_wr_next     = mem_wr_reg;
      if_res_next     = if_res_reg;
      if_done_next    = if_done_reg;
      ls_rdata_next   = ls_rdata_reg;
      ls_done_next    = ls_done_reg;

      if (!rdy_in) begin
         // Paused: data arriving now is dropped, so re-issue from the
         // first byte not yet captured.
         if (state == READ) begin
            beat_idx_next   = rewind_idx;
            beat_valid_next = 1'b1;
            cap_valid_next  = 1'b0;
            mem_a_next      = rewind_addr;
         end
      end else begin
         if_done_next = 1'b0;
         ls_done_next = 1'b0;
         case (state)
            IDLE: begin
               if (!flush && grant_if) begin
                  state_next      = READ;
                  last_ls_next    = 1'b0;
                  owner_ls_next   = 1'b0;
                  base_next       = if_addr;
                  len_next        = CW'(LINE_BYTES);
                  beat_idx_next   = '0;
                  beat_valid_next = 1'b1;
                  cap_valid_next  = 1'b0;
                  mem_a_next      = if_addr;
                  mem_wr_next     = 1'b0;
               end else if (!flush && grant_ls) begin
                  last_ls_next    = 1'b1;
                  owner_ls_next   = 1'b1;
                  base_next       = ls_addr;
                  len_next        = {{(CW-3){1'b0}}, ls_len};
                  wdata_next      = ls_wdata;
                  beat_idx_next   = '0;
                  cap_valid_next  = 1'b0;
                  mem_a_next      = ls_addr;
                  if (ls_store) begin
                     state_next      = WRITE;
                     beat_valid_next = 1'b0;
                     mem_wr_next     = 1'b1;
                     mem_dout_next   = ls_wdata[7:0];
                  end else begin
                     state_next      = READ;
                     beat_valid_next = 1'b1;
                     mem_wr_next     = 1'b0;
                  end
               end
            end
            READ: begin
               if (flush) begin
                  state_next      = IDLE;
                  beat_valid_next = 1'b0;
                  cap_valid_next  = 1'b0;
                  mem_a_next      = '0;
               end else begin
                  if (cap_valid) begin
                     rbuf_next = rbuf_cap;
                     if (cap_idx == last_idx) begin
                        state_next = IDLE;
                        if (owner_ls) begin
                           ls_done_next  = 1'b1;
                           ls_rdata_next = ls_word;
                        end else begin
                           if_done_next = 1'b1;
                           if_res_next  = rbuf_cap;
                        end
                     end
                  end
                  cap_valid_next = beat_valid;
                  cap_idx_next   = beat_idx;
                  if (beat_valid && (beat_idx != last_idx)) begin
                     beat_idx_next = step_idx;
                     mem_a_next    = step_addr;
                  end else begin
                     beat_valid_next = 1'b0;
                     mem_a_next      = '0;
                  end
               end
            end
            WRITE: begin
               // Stores are never aborted by flush: they are architectural.
               if (beat_idx == last_idx) begin
                  state_next    = IDLE;
                  mem_wr_next   = 1'b0;
                  mem_a_next    = '0;
                  mem_dout_next = '0;
                  ls_done_next  = 1'b1;
               end else begin
                  beat_idx_next = step_idx;
                  mem_a_next    = step_addr;
                  mem_dout_next = wdata[wr_bit +: 8];
               end
            end
            default: begin
               state_next  = IDLE;
               mem_wr_next = 1'b0;
               mem_a_next  = '0;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state        <= IDLE;
         last_ls      <= 1'b0;
         owner_ls     <= 1'b0;
         base         <= '0;
         len          <= '0;
         wdata        <= '0;
         beat_idx     <= '0;
         beat_valid   <= 1'b0;
         cap_idx      <= '0;
         cap_valid    <= 1'b0;
         rbuf         <= '0;
         mem_a_reg    <= '0;
         mem_dout_reg <= '0;
         mem_wr_reg   <= 1'b0;
         if_res_reg   <= '0;
         if_done_reg  <= 1'b0;
         ls_rdata_reg <= '0;
         ls_done_reg  <= 1'b0;
      end else begin
         state        <= state_next;
         last_ls      <= last_ls_next;
         owner_ls     <= owner_ls_next;
         base         <= base_next;
         len          <= len_next;
         wdata        <= wdata_next;
         beat_idx     <= beat_idx_next;
         beat_valid   <= beat_valid_next;
         cap_idx      <= cap_idx_next;
         cap_valid    <= cap_valid_next;
         rbuf         <= rbuf_next;
         mem_a_reg    <= mem_a_next;
         mem_dout_reg <= mem_dout_next;
         mem_wr_reg   <= mem_wr_next;
         if_res_reg   <= if_res_next;
         if_done_reg  <= if_done_next;
         ls_rdata_reg <= ls_rdata_next;
         ls_done_reg  <= ls_done_next;
      end
   end

   assign mem_a    = mem_a_reg;
   assign mem_dout = mem_dout_reg;
   assign mem_wr   = mem_wr_reg & rdy_in;   // a paused cycle must never write
   assign if_res   = if_res_reg;
   assign if_done  = if_done_reg;
   assign ls_rdata = ls_rdata_reg;
   assign ls_done  = ls_done_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;
   localparam int LB = 64;

   logic            clk_in = 1'b0;
   logic            rst_in, rdy_in, flush, io_buffer_full;
   logic [7:0]      mem_din = 8'h00;
   logic [7:0]      mem_dout;
   logic [31:0]     mem_a;
   logic            mem_wr;
   logic            if_todo;
   logic [31:0]     if_addr;
   logic [8*LB-1:0] if_res;
   logic            if_done;
   logic            ls_todo;
   logic [31:0]     ls_addr;
   logic [2:0]      ls_len;
   logic            ls_store;
   logic [31:0]     ls_wdata;
   logic [31:0]     ls_rdata;
   logic            ls_done;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(.LINE_BYTES(LB)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
      .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .if_todo(if_todo), .if_addr(if_addr),
      .if_res(if_res), .if_done(if_done), .ls_todo(ls_todo), .ls_addr(ls_addr),
      .ls_len(ls_len), .ls_store(ls_store), .ls_wdata(ls_wdata),
      .ls_rdata(ls_rdata), .ls_done(ls_done)
   );

   always #5 clk_in = ~clk_in;

   // Memory contents: fixed bytes at 0x100..0x103, a hash elsewhere
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h100: return 8'h11;
         32'h101: return 8'h22;
         32'h102: return 8'h33;
         32'h103: return 8'h44;
         default: return a[7:0] ^ a[15:8] ^ 8'h5A;
      endcase
   endfunction

   // Read data for the address presented in the previous cycle
   always @(posedge clk_in) mem_din <= mem_byte(mem_a);

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
      if_todo = 1'b0; if_addr = '0;
      ls_todo = 1'b0; ls_addr = '0; ls_len = 3'd0; ls_store = 1'b0; ls_wdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_in = 1'b0;
      tick(); tick();
      n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a got %h exp 0", mem_a); end
      n_checks++; if (mem_dout !== 8'h0) begin n_fail++; $display("FAIL reset_mem_dout got %h exp 0", mem_dout); end
      n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
      n_checks++; if (if_done !== 1'b0) begin n_fail++; $display("FAIL reset_if_done got %b exp 0", if_done); end
      n_checks++; if (ls_done !== 1'b0) begin n_fail++; $display("FAIL reset_ls_done got %b exp 0", ls_done); end
      n_checks++; if (ls_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_ls_rdata got %h exp 0", ls_rdata); end
      n_checks++; if (if_res !== '0) begin n_fail++; $display("FAIL reset_if_res got nonzero exp 0"); end
      rst_in = 1'b1;
      tick();
      $display("reset released");
   endtask

   task automatic test_load();
      tick(); tick();
      ls_addr = 32'h100; ls_len = 3'd4; ls_store = 1'b0; ls_todo = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c <= 4) begin
            n_checks++; if (mem_a !== 32'h100 + c - 1) begin n_fail++; $display("FAIL load_addr cyc=%0d got %h exp %h", c, mem_a, 32'h100 + c - 1); end
         end else begin
            n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL load_idle_addr cyc=%0d got %h exp 0", c, mem_a); end
         end
         n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL load_wr cyc=%0d got %b exp 0", c, mem_wr); end
         n_checks++; if (ls_done !== (c == 6)) begin n_fail++; $display("FAIL load_done cyc=%0d got %b exp %b", c, ls_done, c == 6); end
         if (ls_done) begin
            n_checks++; if (ls_rdata !== 32'h44332211) begin n_fail++; $display("FAIL load_rdata got %h exp 44332211", ls_rdata); end
            $display("ls load addr=00000100 len=4 data=%h done cyc=%0d", ls_rdata, c);
            ls_todo = 1'b0;
         end
         if (c == 1) begin
            ls_addr = 32'h0000_0BAD; ls_len = 3'd1;   // ignored after grant
         end
      end
   endtask

   task automatic test_store(input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] len, input string tag);
      logic [31:0] ea;
      int l;
      l = int'(len);
      tick(); tick();
      ls_addr = a; ls_len = len; ls_store = 1'b1; ls_wdata = wd; ls_todo = 1'b1;
      for (int c = 1; c <= l + 2; c++) begin
         tick();
         ea = a + 32'(c - 1);
         if (c <= l) begin
            n_checks++; if (mem_wr !== 1'b1 || mem_a !== ea || mem_dout !== wd[8*(c-1) +: 8]) begin
               n_fail++; $display("FAIL store_%s_beat cyc=%0d got wr=%b a=%h d=%h exp wr=1 a=%h d=%h", tag, c, mem_wr, mem_a, mem_dout, ea, wd[8*(c-1) +: 8]); end
         end else begin
            n_checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin
               n_fail++; $display("FAIL store_%s_idle cyc=%0d got wr=%b a=%h exp wr=0 a=0", tag, c, mem_wr, mem_a); end
         end
         n_checks++; if (ls_done !== (c == l + 1)) begin n_fail++; $display("FAIL store_%s_done cyc=%0d got %b exp %b", tag, c, ls_done, c == l + 1); end
         if (ls_done) begin
            $display("ls store %s addr=%h len=%0d done cyc=%0d", tag, a, l, c);
            ls_todo = 1'b0; ls_store = 1'b0;
         end
         if (c == 1) begin
            ls_wdata = ~wd; ls_addr = 32'h0;   // ignored after grant
         end
      end
   endtask

   task automatic test_round_robin();
      logic [8*LB-1:0] exp_line;
      logic exp_ls, after_ls, after_if;
      int seen;
      for (int k = 0; k < LB; k++) exp_line[8*k +: 8] = mem_byte(32'h1000 + 32'(k));
      idle_inputs();
      rst_in = 1'b0; tick(); rst_in = 1'b1; tick();
      if_addr = 32'h1000; ls_addr = 32'h300; ls_len = 3'd1; ls_store = 1'b0;
      if_todo = 1'b1; ls_todo = 1'b1;
      seen = 0; after_ls = 1'b0; after_if = 1'b0;
      for (int c = 1; c <= 400 && seen < 6; c++) begin
         tick();
         if (after_ls) begin
            n_checks++; if (mem_a !== 32'h1000) begin n_fail++; $display("FAIL rr_if_grant cyc=%0d got a=%h exp 00001000", c, mem_a); end
         end
         if (after_if) begin
            n_checks++; if (mem_a !== 32'h300) begin n_fail++; $display("FAIL rr_ls_grant cyc=%0d got a=%h exp 00000300", c, mem_a); end
         end
         after_ls = ls_done; after_if = if_done;
         if (ls_done || if_done) begin
            exp_ls = (seen % 2 == 0);
            n_checks++; if (ls_done !== exp_ls || if_done !== !exp_ls) begin
               n_fail++; $display("FAIL rr_order round=%0d got ls=%b if=%b exp ls=%b if=%b", seen, ls_done, if_done, exp_ls, !exp_ls); end
            if (seen == 0) begin
               n_checks++; if (c != 3) begin n_fail++; $display("FAIL rr_first_done got cyc=%0d exp 3", c); end
            end
            if (ls_done) begin
               n_checks++; if (ls_rdata !== {24'h0, mem_byte(32'h300)}) begin n_fail++; $display("FAIL rr_ls_rdata got %h exp %h", ls_rdata, {24'h0, mem_byte(32'h300)}); end
            end
            if (if_done) begin
               n_checks++; if (if_res !== exp_line) begin n_fail++; $display("FAIL rr_if_res got %h exp %h", if_res, exp_line); end
            end
            $display("rr round=%0d granted=%s done cyc=%0d", seen, ls_done ? "LS" : "IF", c);
            seen++;
            if (seen == 6) begin if_todo = 1'b0; ls_todo = 1'b0; end
         end
      end
      n_checks++; if (seen != 6) begin n_fail++; $display("FAIL rr_rounds got %0d exp 6", seen); end
      if_todo = 1'b0; ls_todo = 1'b0;
   endtask

   task automatic test_io_backpressure();
      tick(); tick();
      // IO store held off by a full UART while a line fill runs
      if_addr = 32'h2000; if_todo = 1'b1;
      ls_addr = 32'h30000; ls_len = 3'd1; ls_store = 1'b1; ls_wdata = 32'h77; ls_todo = 1'b1;
      io_buffer_full = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         tick();
         n_checks++; if (mem_wr !== (c == 67)) begin n_fail++; $display("FAIL io_wr cyc=%0d got %b exp %b", c, mem_wr, c == 67); end
         if (c == 67) begin
            n_checks++; if (mem_a !== 32'h30000 || mem_dout !== 8'h77) begin n_fail++; $display("FAIL io_beat got a=%h d=%h exp a=00030000 d=77", mem_a, mem_dout); end
         end
         n_checks++; if (if_done !== (c == 66)) begin n_fail++; $display("FAIL io_if_done cyc=%0d got %b exp %b", c, if_done, c == 66); end
         n_checks++; if (ls_done !== (c == 68)) begin n_fail++; $display("FAIL io_ls_done cyc=%0d got %b exp %b", c, ls_done, c == 68); end
         if (if_done) begin $display("io if line addr=00002000 done cyc=%0d", c); if_todo = 1'b0; end
         if (ls_done) begin $display("io store addr=00030000 done cyc=%0d", c); ls_todo = 1'b0; end
         if (c == 10) io_buffer_full = 1'b0;
      end
      // Non-IO region store is not held off
      tick(); tick();
      io_buffer_full = 1'b1;
      ls_addr = 32'h20000; ls_wdata = 32'h5C; ls_todo = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         n_checks++; if (mem_wr !== (c == 1)) begin n_fail++; $display("FAIL io_plain_wr cyc=%0d got %b exp %b", c, mem_wr, c == 1); end
         n_checks++; if (ls_done !== (c == 2)) begin n_fail++; $display("FAIL io_plain_done cyc=%0d got %b exp %b", c, ls_done, c == 2); end
         if (ls_done) begin $display("plain store addr=00020000 done cyc=%0d", c); ls_todo = 1'b0; end
      end
      // IO store alone waits, then goes in the cycle the buffer frees
      tick(); tick();
      ls_addr = 32'h30001; ls_todo = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         n_checks++; if (mem_wr !== (c == 6)) begin n_fail++; $display("FAIL io_wait_wr cyc=%0d got %b exp %b", c, mem_wr, c == 6); end
         n_checks++; if (ls_done !== (c == 7)) begin n_fail++; $display("FAIL io_wait_done cyc=%0d got %b exp %b", c, ls_done, c == 7); end
         if (ls_done) begin $display("io store addr=00030001 done cyc=%0d", c); ls_todo = 1'b0; end
         if (c == 5) io_buffer_full = 1'b0;
      end
      ls_store = 1'b0;
   endtask

   task automatic test_flush();
      logic [31:0] exp_w;
      exp_w = {mem_byte(32'h503), mem_byte(32'h502), mem_byte(32'h501), mem_byte(32'h500)};
      tick(); tick();
      if_addr = 32'h4000; if_todo = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c == 20) begin
            n_checks++; if (mem_a !== 32'h4013) begin n_fail++; $display("FAIL flush_pre_addr got %h exp 00004013", mem_a); end
         end
         if (c == 21) begin
            n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL flush_idle_addr got %h exp 0", mem_a); end
         end
         if (c == 22) begin
            n_checks++; if (mem_a !== 32'h500) begin n_fail++; $display("FAIL flush_ls_grant got %h exp 00000500", mem_a); end
         end
         n_checks++; if (if_done !== 1'b0) begin n_fail++; $display("FAIL flush_if_done cyc=%0d got 1 exp 0", c); end
         n_checks++; if (ls_done !== (c == 27)) begin n_fail++; $display("FAIL flush_ls_done cyc=%0d got %b exp %b", c, ls_done, c == 27); end
         if (ls_done) begin
            n_checks++; if (ls_rdata !== exp_w) begin n_fail++; $display("FAIL flush_ls_rdata got %h exp %h", ls_rdata, exp_w); end
            $display("ls load after flush addr=00000500 data=%h done cyc=%0d", ls_rdata, c);
            ls_todo = 1'b0;
         end
         if (c == 1) begin ls_addr = 32'h500; ls_len = 3'd4; ls_store = 1'b0; ls_todo = 1'b1; end
         if (c == 20) flush = 1'b1;
         if (c == 21) begin flush = 1'b0; if_todo = 1'b0; end
      end
   endtask

   task automatic test_pause();
      int done_cyc, nb;
      logic [31:0] wd;
      tick(); tick();
      // Load paused in cycles 3..5
      done_cyc = -1;
      ls_addr = 32'h100; ls_len = 3'd4; ls_store = 1'b0; ls_todo = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL pause_load_wr cyc=%0d got 1 exp 0", c); end
         if (ls_done) begin
            done_cyc = c;
            n_checks++; if (ls_rdata !== 32'h44332211) begin n_fail++; $display("FAIL pause_load_rdata got %h exp 44332211", ls_rdata); end
            $display("paused load addr=00000100 data=%h done cyc=%0d", ls_rdata, c);
            ls_todo = 1'b0;
         end
         if (c == 2) rdy_in = 1'b0;
         if (c == 5) rdy_in = 1'b1;
      end
      n_checks++; if (done_cyc < 9) begin n_fail++; $display("FAIL pause_load_latency got cyc=%0d exp >=9", done_cyc); end
      // Store paused in cycle 2: the beat is held back, not lost or repeated
      tick(); tick();
      wd = 32'h11223344; nb = 0; done_cyc = -1;
      ls_addr = 32'h600; ls_len = 3'd4; ls_store = 1'b1; ls_wdata = wd; ls_todo = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 2) begin
            n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL pause_store_wr got 1 exp 0"); end
         end
         if (mem_wr) begin
            n_checks++; if (nb > 3 || mem_a !== 32'h600 + 32'(nb) || mem_dout !== wd[8*(nb%4) +: 8]) begin
               n_fail++; $display("FAIL pause_store_beat n=%0d got a=%h d=%h exp a=%h d=%h", nb, mem_a, mem_dout, 32'h600 + 32'(nb), wd[8*(nb%4) +: 8]); end
            nb++;
         end
         if (ls_done) begin
            done_cyc = c;
            $display("paused store addr=00000600 beats=%0d done cyc=%0d", nb, c);
            ls_todo = 1'b0; ls_store = 1'b0;
         end
         if (c == 1) rdy_in = 1'b0;
         if (c == 2) rdy_in = 1'b1;
      end
      n_checks++; if (nb != 4) begin n_fail++; $display("FAIL pause_store_beats got %0d exp 4", nb); end
      n_checks++; if (done_cyc != 6) begin n_fail++; $display("FAIL pause_store_done got cyc=%0d exp 6", done_cyc); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load();
      test_store(32'h200, 32'hDEADA5B6, 3'd2, "basic");
      test_store(32'hFFFFFFFF, 32'h0000C3D4, 3'd2, "wrap");
      test_round_robin();
      test_io_backpressure();
      test_flush();
      test_pause();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
